// File: rtl/cbud_mod_counter.sv
// Parametrised cascadable up/down modulus counter with wrap or saturate
// behaviour, combinational carry/borrow-out and a registered terminal-count pulse.
module cbud_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             SD,
    input  logic             LD,
    input  logic             EN,
    input  logic             CAI,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             TCP
);

    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_param_check
        $error("cbud_mod_counter: MODULUS must lie in 2..2**WIDTH and WIDTH in 1..32");
    end

    // One extra bit so MODULUS = 2**WIDTH compares without overflow.
    localparam longint         MAX_L = longint'(MODULUS) - 1;
    localparam logic [WIDTH:0] MAX   = MAX_L[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_Q = MAX[WIDTH-1:0];

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             tcp_reg;
    logic             tcp_next;
    logic             term;
    logic             cnt;
    logic [WIDTH:0]   q_ext;

    assign q_ext = {1'b0, q_reg};
    assign term  = UP ? (q_ext >= MAX) : (q_reg == '0);
    assign cnt   = CAI & EN & ~CD & ~SD & ~LD;

    always_comb begin
        q_next   = q_reg;
        tcp_next = cnt & term;
        if (SD) begin
            q_next = MAX_Q;
        end else if (LD) begin
            q_next = D;
        end else if (CAI && EN) begin
            if (UP) begin
                if (q_ext < MAX)
                    q_next = q_reg + 1'b1;
                else
                    q_next = SATURATE ? MAX_Q : '0;
            end else begin
                if (q_reg == '0)
                    q_next = SATURATE ? '0 : MAX_Q;
                else if (q_ext > MAX)
                    q_next = MAX_Q;  // out-of-range values re-enter at the top
                else
                    q_next = q_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CD) begin
            q_reg   <= '0;
            tcp_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            tcp_reg <= tcp_next;
        end
    end

    // Carry ignores CD/SD/LD so cascaded stages ripple in the same cycle.
    assign CAO = CAI & EN & term;
    assign Q   = q_reg;
    assign TCP = tcp_reg;

endmodule

// File: tb/tb_cbud_mod_counter.sv
// Scoreboard bench: three standalone counters plus a two-stage decade cascade,
// all driven from shared random stimulus and checked against integer models.
module tb_cbud_mod_counter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       cd, sd, ld, en, cai, up;
    logic [3:0] d;
    logic [3:0] q0, q1, q2, qlo, qhi;
    logic       cao0, cao1, cao2, caolo, caohi;
    logic       tcp0, tcp1, tcp2, tcplo, tcphi;
    logic       zero;

    assign zero = 1'b0;

    cbud_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap10 (
        .CLK(CLK), .CD(cd), .SD(sd), .LD(ld), .EN(en), .CAI(cai), .UP(up),
        .D(d), .Q(q0), .CAO(cao0), .TCP(tcp0));
    cbud_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat10 (
        .CLK(CLK), .CD(cd), .SD(sd), .LD(ld), .EN(en), .CAI(cai), .UP(up),
        .D(d), .Q(q1), .CAO(cao1), .TCP(tcp1));
    cbud_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_bin16 (
        .CLK(CLK), .CD(cd), .SD(sd), .LD(ld), .EN(en), .CAI(cai), .UP(up),
        .D(d), .Q(q2), .CAO(cao2), .TCP(tcp2));
    cbud_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo (
        .CLK(CLK), .CD(cd), .SD(zero), .LD(zero), .EN(en), .CAI(cai), .UP(up),
        .D(4'd0), .Q(qlo), .CAO(caolo), .TCP(tcplo));
    cbud_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi (
        .CLK(CLK), .CD(cd), .SD(zero), .LD(zero), .EN(en), .CAI(caolo), .UP(up),
        .D(4'd0), .Q(qhi), .CAO(caohi), .TCP(tcphi));

    typedef struct packed {
        logic [4:0][3:0] q;
        logic [4:0]      tcp;
        logic [4:0]      cao;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    localparam int MODS [3] = '{10, 10, 16};
    localparam bit SATS [3] = '{1'b0, 1'b1, 1'b0};

    // Reference state: plain integers, cascade kept as one 0..99 number.
    int mq [3];
    bit mtcp [5];
    int n;

    function automatic bit at_term(int q, int m, bit dir_up);
        return dir_up ? (q >= m - 1) : (q == 0);
    endfunction

    function automatic int model_next(int q, int m, bit sat, bit icd, bit isd, bit ild,
                                      bit ien, bit icai, bit iup, int dv);
        int top;
        top = m - 1;
        if (icd) return 0;
        if (isd) return top;
        if (ild) return dv;
        if (!(icai && ien)) return q;
        if (iup) begin
            if (q < top) return q + 1;
            return sat ? top : 0;
        end
        if (q == 0) return sat ? 0 : top;
        return (q - 1 > top) ? top : q - 1;
    endfunction

    task automatic issue(input bit icd, isd, ild, ien, icai, iup, input int dv);
        exp_t e;
        bit   tl, th, c;
        int   lo, hi;
        cd = icd; sd = isd; ld = ild; en = ien; cai = icai; up = iup; d = 4'(dv);
        for (int i = 0; i < 3; i++) begin
            e.q[i]   = 4'(mq[i]);
            e.tcp[i] = mtcp[i];
            e.cao[i] = icai & ien & at_term(mq[i], MODS[i], iup);
        end
        lo = n % 10;
        hi = n / 10;
        tl = at_term(lo, 10, iup);
        th = at_term(hi, 10, iup);
        e.q[3] = 4'(lo);  e.tcp[3] = mtcp[3]; e.cao[3] = icai & ien & tl;
        e.q[4] = 4'(hi);  e.tcp[4] = mtcp[4]; e.cao[4] = icai & ien & tl & th;
        exp_q.push_back(e);

        for (int i = 0; i < 3; i++) begin
            mtcp[i] = icai & ien & ~icd & ~isd & ~ild & at_term(mq[i], MODS[i], iup);
            mq[i]   = model_next(mq[i], MODS[i], SATS[i], icd, isd, ild, ien, icai, iup, dv);
        end
        c = icai & ien & ~icd;
        mtcp[3] = c & tl;
        mtcp[4] = c & tl & th;
        if (icd)     n = 0;
        else if (c)  n = iup ? (n + 1) % 100 : (n + 99) % 100;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every cycle presents one observation, checked at the falling edge.
    always @(negedge CLK) begin
        exp_t            e;
        logic [4:0][3:0] aq;
        logic [4:0]      at, ac;
        cycle++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            aq = {qhi, qlo, q2, q1, q0};
            at = {tcphi, tcplo, tcp2, tcp1, tcp0};
            ac = {caohi, caolo, cao2, cao1, cao0};
            for (int i = 0; i < 5; i++) begin
                tests += 3;
                if (aq[i] !== e.q[i]) begin
                    fails++;
                    $display("FAIL Q[%0d] cycle %0d: got %0d expected %0d", i, cycle, aq[i], e.q[i]);
                end
                if (at[i] !== e.tcp[i]) begin
                    fails++;
                    $display("FAIL TCP[%0d] cycle %0d: got %b expected %b", i, cycle, at[i], e.tcp[i]);
                end
                if (ac[i] !== e.cao[i]) begin
                    fails++;
                    $display("FAIL CAO[%0d] cycle %0d: got %b expected %b", i, cycle, ac[i], e.cao[i]);
                end
            end
        end
    end

    initial begin
        bit rup;
        cd = 1'b1; sd = 1'b0; ld = 1'b0; en = 1'b0; cai = 1'b0; up = 1'b1; d = 4'd0;
        for (int i = 0; i < 3; i++) mq[i] = 0;
        for (int i = 0; i < 5; i++) mtcp[i] = 1'b0;
        n = 0;
        @(posedge CLK);
        #1;

        // Up from reset, then down through zero.
        for (int k = 0; k < 12; k++) issue(0, 0, 0, 1, 1, 1, 0);
        issue(1, 0, 0, 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) issue(0, 0, 0, 1, 1, 0, 0);
        // Out-of-range load then count both ways; priority combinations.
        issue(0, 0, 1, 1, 1, 1, 13);
        issue(0, 0, 0, 1, 1, 1, 0);
        issue(0, 0, 1, 1, 1, 0, 13);
        issue(0, 0, 0, 1, 1, 0, 0);
        issue(0, 0, 1, 0, 0, 1, 5);
        issue(1, 1, 1, 1, 1, 1, 5);
        issue(0, 1, 1, 1, 1, 1, 3);
        issue(0, 0, 0, 0, 1, 1, 0);
        issue(0, 0, 0, 0, 1, 1, 0);

        rup = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) rup = ~rup;
            issue($urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 4) != 0, rup, int'($urandom_range(0, 15)));
        end

        // Full decade-cascade sweep from zero.
        issue(1, 0, 0, 1, 1, 1, 0);
        for (int k = 0; k < 102; k++) issue(0, 0, 0, 1, 1, 1, 0);
        issue(0, 0, 0, 0, 0, 1, 0);

        repeat (3) @(negedge CLK);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
